// File: rtl/hidden_bias_sequencer_if.sv
// Valid/ready stream carrying one bias word per beat from the sequencer to the
// accumulator-init path, tagged with its group and lane.
interface hidden_bias_sequencer_if #(
    parameter int GW    = 1,
    parameter int LW    = 4,
    parameter int OUT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [GW-1:0]    out_group;
    logic [LW-1:0]    out_lane;
    logic             out_last;

    modport master (
        output out_valid, out_data, out_group, out_lane, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_group, out_lane, out_last,
        output out_ready
    );
endinterface

// File: rtl/hidden_bias_sequencer.sv
// Walks every bias group of the hidden-layer ROM, shadows each LANES-wide read,
// and streams the biases one per beat. Define HIDDEN_BIAS_SIGNEXT_EN to sign-extend.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// LOAD   | mem_sel = group, shadow captures the ROM row at the edge
// STREAM | presenting shadow[lane] on the stream until accepted
// DONE   | one-cycle completion pulse, then back to IDLE
module hidden_bias_sequencer #(
    parameter int NUM_GROUPS = 2,
    parameter int LANES      = 10,
    parameter int DW         = 8,
    parameter int OUT_W      = 16,
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [GW-1:0]         mem_sel,
    input  logic [LANES*DW-1:0]   mem_data,
    output logic                  busy,
    output logic                  done,
    hidden_bias_sequencer_if.master stream
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    localparam logic [GW-1:0] GROUP_MAX = GW'(NUM_GROUPS - 1);
    localparam logic [LW-1:0] LANE_MAX  = LW'(LANES - 1);

    state_t          state, state_nxt;
    logic [GW-1:0]   group, group_nxt;
    logic [LW-1:0]   lane, lane_nxt;
    logic [DW-1:0]   shadow [LANES];
    logic [DW-1:0]   cur_bias;
    logic            last;
    logic            fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            group <= '0;
            lane  <= '0;
            for (int k = 0; k < LANES; k++) shadow[k] <= '0;
        end else begin
            state <= state_nxt;
            group <= group_nxt;
            lane  <= lane_nxt;
            if (state == S_LOAD) begin
                for (int k = 0; k < LANES; k++) shadow[k] <= mem_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        group_nxt = group;
        lane_nxt  = lane;
        cur_bias  = shadow[lane];
        last      = (group == GROUP_MAX) && (lane == LANE_MAX);
        fire      = (state == S_STREAM) && stream.out_ready;

        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_LOAD;
                    group_nxt = '0;
                    lane_nxt  = '0;
                end
            end
            S_LOAD: state_nxt = S_STREAM;
            S_STREAM: begin
                if (fire) begin
                    if (lane != LANE_MAX) begin
                        lane_nxt = lane + LW'(1);
                    end else if (!last) begin
                        lane_nxt  = '0;
                        group_nxt = group + GW'(1);
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                group_nxt = '0;
                lane_nxt  = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                group_nxt = '0;
                lane_nxt  = '0;
            end
        endcase

        // A beat accepted alongside abort still counts; only the sequence ends.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            group_nxt = '0;
            lane_nxt  = '0;
        end

        stream.out_valid = (state == S_STREAM);
        stream.out_data  = '0;
        stream.out_group = '0;
        stream.out_lane  = '0;
        stream.out_last  = 1'b0;
        if (state == S_STREAM) begin
`ifdef HIDDEN_BIAS_SIGNEXT_EN
            stream.out_data = OUT_W'($signed(cur_bias));
`else
            stream.out_data = OUT_W'(cur_bias);
`endif
            stream.out_group = group;
            stream.out_lane  = lane;
            stream.out_last  = last;
        end

        mem_sel = (state == S_IDLE) ? '0 : group;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE) && !abort;
    end
endmodule

// File: doc/hidden_bias_sequencer.md
Name: hidden_bias_sequencer

Overview:
- Sequences the hidden-layer bias ROM for the neuron MAC datapath.
- Steps the group select through every bias group and captures each group's LANES-wide read into a shadow register.
- Streams the captured biases one per beat to the accumulator-init path over a valid/ready handshake.
- Raises a one-cycle done pulse after the final bias of the final group is accepted.

Parameters:
- NUM_GROUPS, 2, number of bias groups in the ROM (group select range 0..NUM_GROUPS-1)
- LANES, 10, biases per group (one per neuron in a group)
- DW, 8, bias width in ROM
- OUT_W, 16, width of streamed bias word (OUT_W >= DW)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a full sequence; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE
- mem_sel  out  GW  group select to bias ROM; GW = max(1, clog2(NUM_GROUPS))
- mem_data  in  LANES*DW  combinational ROM read; lane k at bits [k*DW +: DW]
- out_valid  out  1  bias word valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  bias word
- out_group  out  GW  group of current word
- out_lane  out  LW  lane of current word; LW = clog2(LANES)
- out_last  out  1  final word of final group
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on sequence completion

Behaviour:
- Reset values: state = IDLE; group = 0; lane = 0; shadow = 0. All outputs 0: mem_sel, out_valid, out_data, out_group, out_lane, out_last, busy, done.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start = 1 -> LOAD; group = 0, lane = 0.
  - start and abort high together: abort wins, stay IDLE.
- LOAD (exactly 1 cycle):
  - mem_sel = group.
  - Shadow register captures mem_data at the clock edge -> STREAM.
  - out_valid = 0.
- STREAM:
  - out_valid = 1.
  - out_data = ext(shadow lane[lane]).
  - out_group = group; out_lane = lane.
  - out_last = (group == NUM_GROUPS-1) && (lane == LANES-1).
- Handshake in STREAM:
  - A beat transfers when out_valid && out_ready.
  - Held data must not change while out_valid = 1 and out_ready = 0.
  - Transfer with lane < LANES-1: lane++.
  - Transfer with lane == LANES-1 and out_last = 0: lane = 0, group++ -> LOAD.
  - Transfer with out_last = 1 -> DONE.
- DONE (1 cycle): done = 1, busy = 1 -> IDLE; group and lane cleared to 0.
- Latency:
  - start sampled at edge N -> LOAD in cycle N+1 -> first out_valid in cycle N+2.
  - Each group costs 1 bubble cycle (LOAD) plus LANES beats.
  - With out_ready held high, a full sequence is NUM_GROUPS*(LANES+1) cycles from LOAD entry to the final transfer, then 1 DONE cycle.
- mem_sel holds the current group in every state except IDLE, where it is 0. The ROM read is combinational, so no wait state is needed.
- abort in LOAD, STREAM or DONE:
  - Next state is IDLE; group and lane are cleared.
  - out_valid drops the following cycle; no done pulse.
  - A beat handshaken in the same cycle as abort counts as transferred, but the sequence still ends without done.
- rst mid-sequence behaves like abort, and additionally clears the shadow register and all outputs.
- start outside IDLE is ignored and is not queued.
- Counter widths:
  - group counter is GW bits and never exceeds NUM_GROUPS-1.
  - lane counter is LW bits and never exceeds LANES-1.
  - Counters do not wrap for non-power-of-2 sizes.

Optional Feature:
- Macro: HIDDEN_BIAS_SIGNEXT_EN.
- Defined: ext() sign-extends the DW-bit bias to OUT_W; biases are treated as two's complement, matching signed accumulators.
- Undefined: ext() zero-extends; out_data[OUT_W-1:DW] = 0.
- Handshake, timing and all other behaviour are identical in both builds.

Test Plan:
- Basic sequence, out_ready = 1:
  - ROM group0 = 0x01..0x0A, group1 = 0x11..0x1A; pulse start.
  - First valid 2 cycles later; 20 words in order 0x01..0x0A, bubble, 0x11..0x1A.
  - out_last only on 0x1A; done 1 cycle after the last transfer; busy low after DONE.
- Backpressure:
  - Drop out_ready for 3 cycles at lane 4 of group 0.
  - out_data holds 0x05 and out_lane holds 4 throughout the stall; no word lost or duplicated.
- Abort:
  - Assert abort while streaming lane 6 of group 1.
  - Next cycle: IDLE, out_valid = 0, no done.
  - A new start replays from group 0 lane 0 (value 0x01).
- Reset mid-LOAD:
  - Assert rst during the group-1 LOAD cycle.
  - All outputs 0 next cycle; mem_sel = 0; start afterward works normally.
- Sign extension:
  - Bias 0xF3.
  - With HIDDEN_BIAS_SIGNEXT_EN: out_data = 0xFFF3.
  - Without: 0x00F3.
  - Bias 0x7F gives 0x007F in both builds.
- Start ignored while busy:
  - Pulse start during STREAM of group 0.
  - Sequence unaffected; exactly one done pulse; no restart afterward.
